// File: rtl/demux16_1to4_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux16_1to4_buf_pkg : shared constants and channel state encoding |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package demux16_1to4_buf_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [0:0] {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

endpackage : demux16_1to4_buf_pkg
`default_nettype wire

// File: rtl/demux16_1to4_buf_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_slot : one-entry holding register with load/drain handshake  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module demux_slot
  import demux16_1to4_buf_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOAD,
  input  logic [DATA_SIZE-1:0] D_IN,
  input  logic                 DRAIN,
  output logic [DATA_SIZE-1:0] D_OUT,
  output logic                 VALID
);

  ch_state_t              r_state;
  ch_state_t              w_state_nxt;
  logic [DATA_SIZE-1:0]   r_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= CH_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (LOAD) begin
        r_data <= D_IN;
      end
    end
  end

  // A load while draining keeps the slot full: the new word replaces the old.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CH_EMPTY: if (LOAD)           w_state_nxt = CH_FULL;
      CH_FULL:  if (DRAIN && !LOAD) w_state_nxt = CH_EMPTY;
      default:                      w_state_nxt = CH_EMPTY;
    endcase
  end

  assign D_OUT = r_data;
  assign VALID = (r_state == CH_FULL);

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux16_1to4_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux16_1to4_buf : registered 1-to-4 distributor, valid/ready      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module demux16_1to4_buf
  import demux16_1to4_buf_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [SEL_W-1:0]     SEL,
  input  logic [DATA_SIZE-1:0] D_IN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [DATA_SIZE-1:0] D_OUT0,
  output logic [DATA_SIZE-1:0] D_OUT1,
  output logic [DATA_SIZE-1:0] D_OUT2,
  output logic [DATA_SIZE-1:0] D_OUT3,
  output logic [NUM_CH-1:0]    OUT_VALID,
  input  logic [NUM_CH-1:0]    OUT_READY
);

  logic                 w_accept;
  logic [NUM_CH-1:0]    w_load;
  logic [DATA_SIZE-1:0] w_data [NUM_CH];

  // Ready only looks at the selected channel; it never depends on IN_VALID.
  assign IN_READY = ~OUT_VALID[SEL] | OUT_READY[SEL];
  assign w_accept = IN_VALID & IN_READY;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      assign w_load[i] = w_accept && (SEL == SEL_W'(i));

      demux_slot #(
        .DATA_SIZE (DATA_SIZE)
      ) u_slot (
        .CLK   (CLK),
        .RST   (RST),
        .LOAD  (w_load[i]),
        .D_IN  (D_IN),
        .DRAIN (OUT_READY[i]),
        .D_OUT (w_data[i]),
        .VALID (OUT_VALID[i])
      );
    end
  endgenerate

  assign D_OUT0 = w_data[0];
  assign D_OUT1 = w_data[1];
  assign D_OUT2 = w_data[2];
  assign D_OUT3 = w_data[3];

endmodule : demux16_1to4_buf
`default_nettype wire

// File: tb/tb_demux16_1to4_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_demux16_1to4_buf : directed self-checking bench                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_demux16_1to4_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [15:0] d_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] d_out0, d_out1, d_out2, d_out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux16_1to4_buf #(.DATA_SIZE(16)) dut (
    .CLK       (clk),
    .RST       (rst),
    .SEL       (sel),
    .D_IN      (d_in),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .D_OUT0    (d_out0),
    .D_OUT1    (d_out1),
    .D_OUT2    (d_out2),
    .D_OUT3    (d_out3),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] din;
    logic        vld;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [15:0] exp_d0, exp_d1, exp_d2, exp_d3;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic [1:0] s, input logic [15:0] d, input logic v,
                              input logic [3:0] o, input logic r, input logic [3:0] ov,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
    vec_t t;
    t.sel = s; t.din = d; t.vld = v; t.ordy = o; t.exp_rdy = r; t.exp_ov = ov;
    t.exp_d0 = e0; t.exp_d1 = e1; t.exp_d2 = e2; t.exp_d3 = e3;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] s, input logic [15:0] d,
                       input logic v, input logic [3:0] o);
    @(negedge clk);
    rst = r; sel = s; d_in = d; in_valid = v; out_ready = o;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ov, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    chk({tag, ".ov"}, 32'(out_valid), 32'(ov));
    chk({tag, ".d0"}, 32'(d_out0), 32'(e0));
    chk({tag, ".d1"}, 32'(d_out1), 32'(e1));
    chk({tag, ".d2"}, 32'(d_out2), 32'(e2));
    chk({tag, ".d3"}, 32'(d_out3), 32'(e3));
  endtask

  initial begin
    //               sel  din       vld  ordy     rdy   ov       d0        d1       d2        d3
    vecs[0]  = mk(2'd2, 16'hA5A5, 1'b1, 4'b0000, 1'b1, 4'b0100, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
    vecs[1]  = mk(2'd2, 16'hA5A5, 1'b0, 4'b0000, 1'b0, 4'b0100, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
    vecs[2]  = mk(2'd2, 16'hA5A5, 1'b0, 4'b0100, 1'b1, 4'b0000, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
    vecs[3]  = mk(2'd0, 16'h0001, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h0001, 16'h0000, 16'hA5A5, 16'h0000);
    vecs[4]  = mk(2'd1, 16'h0002, 1'b1, 4'b0000, 1'b1, 4'b0011, 16'h0001, 16'h0002, 16'hA5A5, 16'h0000);
    vecs[5]  = mk(2'd2, 16'h0003, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h0001, 16'h0002, 16'h0003, 16'h0000);
    vecs[6]  = mk(2'd3, 16'h0004, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    vecs[7]  = mk(2'd0, 16'h0009, 1'b1, 4'b0000, 1'b0, 4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    vecs[8]  = mk(2'd3, 16'h0009, 1'b1, 4'b0000, 1'b0, 4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    vecs[9]  = mk(2'd3, 16'hBEEF, 1'b1, 4'b1000, 1'b1, 4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'hBEEF);
    vecs[10] = mk(2'd0, 16'h5555, 1'b1, 4'b1000, 1'b0, 4'b0111, 16'h0001, 16'h0002, 16'h0003, 16'hBEEF);
    vecs[11] = mk(2'd1, 16'h7777, 1'b1, 4'b0001, 1'b0, 4'b0110, 16'h0001, 16'h0002, 16'h0003, 16'hBEEF);
    vecs[12] = mk(2'd0, 16'h7777, 1'b1, 4'b0010, 1'b1, 4'b0101, 16'h7777, 16'h0002, 16'h0003, 16'hBEEF);

    rst = 1'b1; sel = 2'd0; d_in = 16'h0; in_valid = 1'b0; out_ready = 4'b0000;

    // Reset for two cycles, then idle.
    after_edge();
    after_edge();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 4'b0000);
    chk_state("reset", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("reset.rdy", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      drive(1'b0, vecs[i].sel, vecs[i].din, vecs[i].vld, vecs[i].ordy);
      chk($sformatf("vec%0d.rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      after_edge();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_d0,
                vecs[i].exp_d1, vecs[i].exp_d2, vecs[i].exp_d3);
    end

    // Back-pressure: fill channel 1, then stall a new word for three cycles.
    drive(1'b0, 2'd1, 16'h0F0F, 1'b1, 4'b0000);
    chk("stall.fill.rdy", 32'(in_ready), 32'd1);
    after_edge();
    chk_state("stall.fill", 4'b0111, 16'h7777, 16'h0F0F, 16'h0003, 16'hBEEF);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'd1, 16'h1234, 1'b1, 4'b0000);
      chk($sformatf("stall%0d.rdy", c), 32'(in_ready), 32'd0);
      after_edge();
      chk_state($sformatf("stall%0d", c), 4'b0111, 16'h7777, 16'h0F0F, 16'h0003, 16'hBEEF);
    end
    drive(1'b0, 2'd1, 16'h1234, 1'b1, 4'b0010);
    chk("release.rdy", 32'(in_ready), 32'd1);
    after_edge();
    chk_state("release", 4'b0111, 16'h7777, 16'h1234, 16'h0003, 16'hBEEF);

    // Build OUT_VALID=1011: accept to 3 while draining 2.
    drive(1'b0, 2'd3, 16'hAAAA, 1'b1, 4'b0100);
    chk("pre_rst.rdy", 32'(in_ready), 32'd1);
    after_edge();
    chk_state("pre_rst", 4'b1011, 16'h7777, 16'h1234, 16'h0003, 16'hAAAA);

    // Reset coincident with an accept to channel 2 drops everything.
    drive(1'b1, 2'd2, 16'hCCCC, 1'b1, 4'b0000);
    after_edge();
    drive(1'b0, 2'd2, 16'hCCCC, 1'b0, 4'b0000);
    chk_state("midrst", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("midrst.rdy", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux16_1to4_buf
`default_nettype wire
